// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-issue instruction fetch stage with decode back-pressure,
//               branch redirect and halt at the end of instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [4:0]  inst_addr,
    input  logic [31:0] inst_i,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        halted
);

    localparam logic [31:0] c_end = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_if_valid;
    logic        w_valid_nxt;
    logic [31:0] r_if_inst;
    logic [31:0] w_inst_nxt;
    logic [31:0] r_if_pc;
    logic [31:0] w_if_pc_nxt;
    logic        r_halted;

    logic [31:0] w_pc_inc;
    logic [31:0] w_red_pc;
    logic        w_advance;
    logic        w_unused;

    assign w_pc_inc  = r_pc + 32'd4;
    assign w_red_pc  = {redirect_pc[31:2], 2'b00};
    assign w_advance = (r_state == S_RUN) && (!r_if_valid || dec_ready) && !redirect;
    assign w_unused  = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_inst  <= 32'h0;
            r_if_pc    <= 32'h0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_valid_nxt;
            r_if_inst  <= w_inst_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_halted   <= (w_state_nxt == S_HALT);
        end
    end

    // Redirect outranks everything except reset; a flushed slot keeps its
    // stale data but is marked invalid.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_if_valid;
        w_inst_nxt  = r_if_inst;
        w_if_pc_nxt = r_if_pc;
        if (redirect) begin
            w_pc_nxt    = w_red_pc;
            w_valid_nxt = 1'b0;
            w_state_nxt = (w_red_pc < c_end) ? S_RUN : S_HALT;
        end else begin
            case (r_state)
                S_BOOT: begin
                    w_state_nxt = (r_pc >= c_end) ? S_HALT : S_RUN;
                end
                S_RUN: begin
                    if (w_advance) begin
                        w_inst_nxt  = inst_i;
                        w_if_pc_nxt = r_pc;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        // Last word is latched normally, then fetch stops.
                        if (w_pc_inc >= c_end) begin
                            w_state_nxt = S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    if (dec_ready) begin
                        w_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_BOOT;
                end
            endcase
        end
    end

    assign inst_addr = r_pc[6:2];
    assign pc        = r_pc;
    assign if_valid  = r_if_valid;
    assign if_inst   = r_if_inst;
    assign if_pc     = r_if_pc;
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed table-driven bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  inst_addr;
    logic [31:0] inst_i;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        halted;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst_n;
        logic        dr;
        logic        red;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_if_pc;
        logic [31:0] e_inst;
        logic        e_halted;
        logic        chk_data;
    } vec_t;

    vec_t tbl[$];
    int   split;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .inst_addr   (inst_addr),
        .inst_i      (inst_i),
        .dec_ready   (dec_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a distinct pattern per word
    function automatic logic [31:0] memword(input logic [4:0] a);
        return {16'hC0DE, 3'b000, a, 3'b111, ~a};
    endfunction

    assign inst_i = memword(inst_addr);

    function automatic void add(input logic rst_n, input logic dr, input logic red,
                                input logic [31:0] rpc, input logic [31:0] e_pc,
                                input logic e_valid, input logic [31:0] e_if_pc,
                                input logic e_halted, input logic chk_data);
        vec_t v;
        v.rst_n    = rst_n;
        v.dr       = dr;
        v.red      = red;
        v.rpc      = rpc;
        v.e_pc     = e_pc;
        v.e_valid  = e_valid;
        v.e_if_pc  = e_if_pc;
        v.e_inst   = e_valid ? memword(e_if_pc[6:2]) : 32'h0;
        v.e_halted = e_halted;
        v.chk_data = chk_data;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL row%0d %s: got %h want %h", row, name, got, want);
        end
    endtask

    task automatic apply(input int row);
        logic [31:0] e_addr;
        rst         = tbl[row].rst_n;
        dec_ready   = tbl[row].dr;
        redirect    = tbl[row].red;
        redirect_pc = tbl[row].rpc;
        @(posedge clk);
        #1;
        e_addr = {27'h0, tbl[row].e_pc[6:2]};
        chk("pc", row, pc, tbl[row].e_pc);
        chk("inst_addr", row, {27'h0, inst_addr}, e_addr);
        chk("if_valid", row, {31'h0, if_valid}, {31'h0, tbl[row].e_valid});
        chk("halted", row, {31'h0, halted}, {31'h0, tbl[row].e_halted});
        if (tbl[row].chk_data) begin
            chk("if_pc", row, if_pc, tbl[row].e_if_pc);
            chk("if_inst", row, if_inst, tbl[row].e_inst);
        end
    endtask

    initial begin
        rst         = 1'b0;
        dec_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset, BOOT, free run
        add(0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        add(0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        add(1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        for (int a = 0; a < 3; a++) begin
            add(1, 1, 0, 0, 32'(4 * a + 4), 1, 32'(4 * a), 0, 1);
        end
        // Stall while if_pc=8
        for (int k = 0; k < 3; k++) begin
            add(1, 0, 0, 0, 32'd12, 1, 32'd8, 0, 1);
        end
        add(1, 1, 0, 0, 32'd16, 1, 32'd12, 0, 1);
        // Misaligned redirect during a stall
        add(1, 0, 0, 0, 32'd16, 1, 32'd12, 0, 1);
        add(1, 0, 1, 32'h23, 32'h20, 0, 32'h0, 0, 0);
        add(1, 1, 0, 0, 32'h24, 1, 32'h20, 0, 1);
        // Run to the end of memory
        for (int a = 32'h24; a <= 124; a += 4) begin
            add(1, 1, 0, 0, 32'(a + 4), 1, 32'(a), (a == 124), 1);
        end
        add(1, 0, 0, 0, 32'd128, 1, 32'd124, 1, 1);
        for (int k = 0; k < 11; k++) begin
            add(1, 1, 0, 0, 32'd128, 0, 32'h0, 1, 0);
        end
        // Redirect out of HALT, redirect into HALT
        add(1, 0, 1, 32'd4, 32'd4, 0, 32'h0, 0, 0);
        add(1, 1, 0, 0, 32'd8, 1, 32'd4, 0, 1);
        add(1, 1, 1, 32'h200, 32'h200, 0, 32'h0, 1, 0);
        add(1, 1, 0, 0, 32'h200, 0, 32'h0, 1, 0);
        add(1, 1, 1, 32'd36, 32'd36, 0, 32'h0, 0, 0);
        add(1, 1, 0, 0, 32'd40, 1, 32'd36, 0, 1);
        split = tbl.size();
        // Reset beats a simultaneous redirect, then redirect out of BOOT
        add(0, 1, 1, 32'h10, 32'h0, 0, 32'h0, 0, 1);
        add(1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        add(1, 1, 0, 0, 32'h4, 1, 32'h0, 0, 1);
        add(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        add(1, 1, 1, 32'd8, 32'd8, 0, 32'h0, 0, 0);
        add(1, 1, 0, 0, 32'd12, 1, 32'd8, 0, 1);

        for (int r = 0; r < split; r++) begin
            apply(r);
        end

        // Reset has no effect before the clock edge
        rst      = 1'b0;
        redirect = 1'b1;
        #2;
        chk("async_pc", -1, pc, 32'd40);
        chk("async_valid", -1, {31'h0, if_valid}, 32'h1);
        chk("async_if_pc", -1, if_pc, 32'd36);

        for (int r = split; r < tbl.size(); r++) begin
            apply(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
